// File: rtl/status_vector_pkg.sv
// Shared helpers for the status-vector family of in-order status queues.
// Latency: n/a (package: constant functions only).
// Backpressure: n/a.
//
// Contents:
//   clog2     - ceiling log2 usable in parameter expressions
//   tag_width - width of an entry tag for a given queue depth
package status_vector_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Tag width for a queue of the given depth. Depth is a power of two
  // and at least 2, so the tag is never narrower than one bit, but the
  // floor keeps degenerate parameterisations from producing [-1:0] buses.
  function automatic int tag_width(input int depth);
    int w;
    w = clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : status_vector_pkg

// File: rtl/status_vector_slot.sv
// One status-queue entry: alloc flag, done flag and a WIDTH-bit value.
// Latency: strobes take effect on the next rising edge; outputs are the raw registers.
// Backpressure: none; the parent resolves acceptance and collisions before strobing.
//
// Ports:
//   clk_i, rst_i, flush_i       - clock, sync active-high reset, sync clear
//   alloc_i, alloc_done_i,
//   alloc_value_i               - allocate this entry with initial done/value
//   free_i                      - retire this entry (clears alloc and done)
//   upd_i, upd_value_i          - overwrite value and mark done
//   alloc_o, done_o, data_o     - registered entry state
module status_vector_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic             alloc_done_i,
  input  logic [WIDTH-1:0] alloc_value_i,
  input  logic             free_i,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] upd_value_i,
  output logic             alloc_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  logic             alloc_q;
  logic             done_q;
  logic [WIDTH-1:0] data_q;

  logic clear;
  assign clear = rst_i | flush_i;

  // The parent never allocates and frees the same entry in one cycle
  // (an entry is free-able only when allocated, allocatable only when
  // not), so the ordering below only matters against clear.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      alloc_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (alloc_i) begin
      alloc_q <= 1'b1;
      done_q  <= alloc_done_i;
    end else if (free_i) begin
      alloc_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (upd_i) begin
      done_q  <= 1'b1;
    end
  end

  // The value is deliberately left untouched by reset/flush: it is only
  // observed while the entry is allocated and done, and both flags clear.
  always_ff @(posedge clk_i) begin
    if (!clear) begin
      if (alloc_i) begin
        data_q <= alloc_value_i;
      end else if (upd_i) begin
        data_q <= upd_value_i;
      end
    end
  end

  assign alloc_o = alloc_q;
  assign done_o  = done_q;
  assign data_o  = data_q;

endmodule : status_vector_slot

// File: rtl/status_tag_vector.sv
// In-order status queue: push allocates a tagged entry, updates complete entries
// out of order by tag, pull retires the oldest entry once it is done.
// Latency: push/update/pull visible on outputs 1 cycle after the accepting edge.
// Backpressure: push dropped while full; pull ignored while the head is not valid.
//
// Ports:
//   clk_i, rst_i, flush_i                 - clock, sync active-high reset, sync clear
//   push_i, push_value_i, push_done_i     - allocate at tail; push_tag_o is the tag it gets
//   upd_i, upd_tag_i, upd_value_i         - write value and mark done for an allocated tag
//   pull_i                                - retire head when valid_o
//   value_o, valid_o                      - head value (0 unless valid), head allocated & done
//   empty_o, full_o, count_o              - occupancy
module status_tag_vector
  import status_vector_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 8,
  localparam int TW    = tag_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_value_i,
  input  logic             push_done_i,
  output logic [TW-1:0]    push_tag_o,
  input  logic             upd_i,
  input  logic [TW-1:0]    upd_tag_i,
  input  logic [WIDTH-1:0] upd_value_i,
  input  logic             pull_i,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [TW:0]      count_o
);

  localparam int CW = TW + 1;

  logic [TW-1:0] head_q;
  logic [TW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [DEPTH-1:0] slot_alloc;
  logic [DEPTH-1:0] slot_done;
  logic [WIDTH-1:0] slot_data [DEPTH];

  logic [DEPTH-1:0] alloc_stb;
  logic [DEPTH-1:0] free_stb;
  logic [DEPTH-1:0] upd_stb;

  logic head_valid;
  logic push_acc;
  logic pull_acc;
  logic upd_acc;

  // ------------------------------------------------------------------
  // Acceptance: everything is decided on pre-edge registered state.
  // A full queue rejects a push even if the head retires this cycle,
  // because the slot at tail is still the allocated head.
  // ------------------------------------------------------------------
  assign head_valid = slot_alloc[head_q] & slot_done[head_q];
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);

  assign push_acc = push_i & ~full_o;
  assign pull_acc = pull_i & head_valid;

  // An update only lands on an entry that is allocated now. The entry
  // being pushed this cycle is still free, so it is naturally excluded;
  // the entry being retired this cycle must be excluded explicitly so
  // the retired value is the one the puller saw.
  assign upd_acc = upd_i & slot_alloc[upd_tag_i]
                 & ~(pull_acc & (upd_tag_i == head_q));

  // ------------------------------------------------------------------
  // Entry storage
  // ------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign alloc_stb[i] = push_acc & (tail_q    == TW'(i));
    assign free_stb[i]  = pull_acc & (head_q    == TW'(i));
    assign upd_stb[i]   = upd_acc  & (upd_tag_i == TW'(i));

    status_vector_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .alloc_i       (alloc_stb[i]),
      .alloc_done_i  (push_done_i),
      .alloc_value_i (push_value_i),
      .free_i        (free_stb[i]),
      .upd_i         (upd_stb[i]),
      .upd_value_i   (upd_value_i),
      .alloc_o       (slot_alloc[i]),
      .done_o        (slot_done[i]),
      .data_o        (slot_data[i])
    );
  end

  // ------------------------------------------------------------------
  // Pointers and occupancy. Pointers are exactly TW bits wide, so the
  // natural binary overflow implements the modulo-DEPTH wrap.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_acc) begin
        tail_q <= tail_q + TW'(1);
      end
      if (pull_acc) begin
        head_q <= head_q + TW'(1);
      end
      count_q <= count_q + CW'(push_acc) - CW'(pull_acc);
    end
  end

  // ------------------------------------------------------------------
  // Outputs: purely from registered state.
  // ------------------------------------------------------------------
  assign valid_o    = head_valid;
  assign value_o    = head_valid ? slot_data[head_q] : '0;
  assign count_o    = count_q;
  assign push_tag_o = tail_q;

endmodule : status_tag_vector

// File: tb/tb_status_tag_vector.sv
// Self-checking bench for status_tag_vector: directed scenarios followed by
// randomized traffic, all compared against a tagged-queue reference model.
// Latency: n/a. Backpressure: n/a.
module tb_status_tag_vector;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int TW    = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             push_i = 1'b0;
  logic [WIDTH-1:0] push_value_i = '0;
  logic             push_done_i = 1'b0;
  logic [TW-1:0]    push_tag_o;
  logic             upd_i = 1'b0;
  logic [TW-1:0]    upd_tag_i = '0;
  logic [WIDTH-1:0] upd_value_i = '0;
  logic             pull_i = 1'b0;
  logic [WIDTH-1:0] value_o;
  logic             valid_o;
  logic             empty_o;
  logic             full_o;
  logic [TW:0]      count_o;

  status_tag_vector #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .push_value_i (push_value_i),
    .push_done_i  (push_done_i),
    .push_tag_o   (push_tag_o),
    .upd_i        (upd_i),
    .upd_tag_i    (upd_tag_i),
    .upd_value_i  (upd_value_i),
    .pull_i       (pull_i),
    .value_o      (value_o),
    .valid_o      (valid_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered list of tagged entries ----
  typedef struct {
    int tag;
    bit done;
    int val;
  } ent_t;

  ent_t mq[$];
  int   m_next = 0;

  task automatic model_apply(input bit rst, input bit flush, input bit push, input bit pd,
                             input int pv, input bit upd, input int ut, input int uv,
                             input bit pull);
    bit   pull_ok;
    bit   push_ok;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_next = 0;
      return;
    end
    pull_ok = pull && (mq.size() > 0) && mq[0].done;
    push_ok = push && (mq.size() < DEPTH);
    if (upd) begin
      foreach (mq[k]) begin
        if (mq[k].tag == ut && !(pull_ok && k == 0)) begin
          mq[k].done = 1'b1;
          mq[k].val  = uv;
        end
      end
    end
    if (pull_ok) void'(mq.pop_front());
    if (push_ok) begin
      e.tag  = m_next;
      e.done = pd;
      e.val  = pv;
      mq.push_back(e);
      m_next = (m_next + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs(input string where);
    bit m_valid;
    int m_value;
    m_valid = (mq.size() > 0) && mq[0].done;
    m_value = m_valid ? mq[0].val : 0;
    chk({where, ".valid"},    32'(valid_o),    32'(m_valid));
    chk({where, ".value"},    32'(value_o),    32'(m_value));
    chk({where, ".count"},    32'(count_o),    32'(mq.size()));
    chk({where, ".empty"},    32'(empty_o),    32'(mq.size() == 0));
    chk({where, ".full"},     32'(full_o),     32'(mq.size() == DEPTH));
    chk({where, ".push_tag"}, 32'(push_tag_o), 32'(m_next));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic step(input string where, input bit rst, input bit flush,
                      input bit push, input bit pd, input int pv,
                      input bit upd, input int ut, input int uv, input bit pull);
    rst_i        = rst;
    flush_i      = flush;
    push_i       = push;
    push_done_i  = pd;
    push_value_i = WIDTH'(pv);
    upd_i        = upd;
    upd_tag_i    = TW'(ut);
    upd_value_i  = WIDTH'(uv);
    pull_i       = pull;
    @(posedge clk_i);
    model_apply(rst, flush, push, pd, pv, upd, ut, uv, pull);
    #1;
    rst_i = 1'b0; flush_i = 1'b0; push_i = 1'b0; upd_i = 1'b0; pull_i = 1'b0;
    check_outputs(where);
  endtask

  task automatic do_reset(input string where);
    step(where, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_push(input string where, input int v, input bit d);
    step(where, 0, 0, 1, d, v, 0, 0, 0, 0);
  endtask
  task automatic do_upd(input string where, input int t, input int v);
    step(where, 0, 0, 0, 0, 0, 1, t, v, 0);
  endtask
  task automatic do_pull(input string where);
    step(where, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // ---- reset and basic push ----
    do_reset("rst");
    chk("rst.empty_const", 32'(empty_o), 32'd1);
    chk("rst.tag0", 32'(push_tag_o), 32'd0);
    do_push("basic", 8'h11, 1);
    chk("basic.value_const", 32'(value_o), 32'h11);
    chk("basic.count_const", 32'(count_o), 32'd1);
    do_pull("basic.pull");

    // ---- out-of-order completion ----
    do_reset("ooo.rst");
    do_push("ooo.p0", 8'hA0, 0);
    do_push("ooo.p1", 8'hA1, 0);
    do_push("ooo.p2", 8'hA2, 0);
    do_upd("ooo.u2", 2, 8'h22);
    do_upd("ooo.u1", 1, 8'h21);
    chk("ooo.not_valid", 32'(valid_o), 32'd0);
    do_upd("ooo.u0", 0, 8'h20);
    chk("ooo.head0", 32'(value_o), 32'h20);
    do_pull("ooo.pull0");
    chk("ooo.head1", 32'(value_o), 32'h21);
    do_pull("ooo.pull1");
    chk("ooo.head2", 32'(value_o), 32'h22);
    do_pull("ooo.pull2");
    chk("ooo.empty", 32'(empty_o), 32'd1);

    // ---- full and wrap-around ----
    do_reset("full.rst");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("full.tag3", 32'(push_tag_o), 32'd3);
      do_push("full.fill", 8'h40 + i, 1);
    end
    chk("full.full", 32'(full_o), 32'd1);
    chk("full.wrap", 32'(push_tag_o), 32'd0);
    do_push("full.drop", 8'h55, 1);
    chk("full.drop_count", 32'(count_o), 32'd4);
    step("full.pushpull", 0, 0, 1, 1, 8'h66, 0, 0, 0, 1);
    chk("full.pushpull_count", 32'(count_o), 32'd3);
    do_push("full.more", 8'h77, 1);
    chk("full.tag_adv", 32'(push_tag_o), 32'd1);

    // ---- collisions ----
    do_reset("col.rst");
    do_push("col.p", 8'h30, 1);
    chk("col.head_old", 32'(value_o), 32'h30);
    step("col.upd_pull", 0, 0, 0, 0, 0, 1, 0, 8'h99, 1);
    chk("col.empty", 32'(empty_o), 32'd1);
    do_reset("col.rst2");
    do_upd("col.unalloc", 3, 8'h77);
    for (int i = 0; i < 3; i++) do_push("col.fill", 8'h50 + i, 1);
    for (int i = 0; i < 3; i++) do_pull("col.drain");
    chk("col.tag3", 32'(push_tag_o), 32'd3);
    do_push("col.p3", 8'h44, 0);
    chk("col.p3_notvalid", 32'(valid_o), 32'd0);

    // ---- flush mid-operation ----
    do_reset("fl.rst");
    for (int i = 0; i < 3; i++) do_push("fl.fill", 8'h60 + i, 0);
    step("fl.flush", 0, 1, 1, 1, 8'hEE, 1, 1, 8'hDD, 0);
    chk("fl.count", 32'(count_o), 32'd0);
    chk("fl.tag", 32'(push_tag_o), 32'd0);
    do_push("fl.after", 8'h12, 1);
    chk("fl.after_val", 32'(value_o), 32'h12);

    // ---- pull on an undone head ----
    do_reset("ud.rst");
    do_push("ud.p", 8'h66, 0);
    for (int i = 0; i < 5; i++) begin
      do_pull("ud.hold");
      chk("ud.hold_count", 32'(count_o), 32'd1);
    end
    step("ud.upd", 0, 0, 0, 0, 0, 1, 0, 8'h67, 1);
    chk("ud.upd_count", 32'(count_o), 32'd1);
    chk("ud.upd_value", 32'(value_o), 32'h67);
    do_pull("ud.pull");
    chk("ud.retired", 32'(count_o), 32'd0);

    // ---- randomized traffic ----
    do_reset("rnd.rst");
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_flush, r_push, r_pd, r_upd, r_pull;
      int r_pv, r_ut, r_uv;
      r_rst   = ($urandom_range(0, 255) == 0);
      r_flush = ($urandom_range(0, 99) == 0);
      r_push  = ($urandom_range(0, 99) < 50);
      r_pd    = ($urandom_range(0, 99) < 40);
      r_upd   = ($urandom_range(0, 99) < 45);
      r_pull  = ($urandom_range(0, 99) < 55);
      r_pv    = int'($urandom_range(0, 255));
      r_ut    = int'($urandom_range(0, DEPTH - 1));
      r_uv    = int'($urandom_range(0, 255));
      step("rnd", r_rst, r_flush, r_push, r_pd, r_pv, r_upd, r_ut, r_uv, r_pull);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_status_tag_vector

// File: doc/status_tag_vector.md
# status_tag_vector

Parametrised successor to the 1-bit status value vector. It is an in-order status queue of `DEPTH` entries, each `WIDTH` bits wide. A push allocates an entry and returns its tag. The entry's value can be rewritten later, out of order, through a tag-addressed update port. Pull retires only the oldest entry, and only once it is marked done. It sits between issue logic, which allocates, completion sources, which update, and in-order retire logic, which pulls.

## Interface
- `DEPTH`, 32: number of entries; power of two, ≥ 2.
- `WIDTH`, 8: value width in bits; ≥ 1.
- `TW`, derived = clog2(`DEPTH`): tag width; not overridable.

Ports:
- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: synchronous clear with the same effect as reset.
- `push_i` in 1: allocate a new entry at the tail.
- `push_value_i` in `WIDTH`: initial value of the pushed entry.
- `push_done_i` in 1: the pushed entry is complete at allocation.
- `push_tag_o` out `TW`: tag the next accepted push receives (equals the tail pointer).
- `upd_i` in 1: update request.
- `upd_tag_i` in `TW`: target entry of the update.
- `upd_value_i` in `WIDTH`: new value; an update also marks the entry done.
- `pull_i` in 1: retire the head entry.
- `value_o` out `WIDTH`: head value; forced to 0 when `valid_o` = 0.
- `valid_o` out 1: head entry is allocated and done.
- `empty_o` out 1: count = 0.
- `full_o` out 1: count = `DEPTH`.
- `count_o` out `TW`+1: number of allocated entries.

## Operation
- State:
  - per-entry `alloc`, `done`, `data` registers;
  - `head` and `tail` pointers, `TW` bits each, wrapping modulo `DEPTH`;
  - `count`, `TW`+1 bits.
- Push acceptance:
  - A push is accepted when `push_i` = 1 and `full_o` = 0.
  - On acceptance, `slot[tail]` gets alloc = 1, done = `push_done_i`, data = `push_value_i`, and `tail` increments.
  - `push_i` while full is dropped; state is unchanged.
- Pull acceptance:
  - A pull is accepted when `pull_i` = 1 and `valid_o` = 1.
  - On acceptance, `slot[head]` gets alloc = 0 and done = 0, and `head` increments.
  - `pull_i` while `valid_o` = 0 is ignored, including when the head is allocated but not done.
- Update:
  - An update applies when `upd_i` = 1 and `alloc[upd_tag_i]` = 1, evaluated on the registered state.
  - It writes data and sets done = 1.
  - An update to an unallocated tag is ignored.
  - Repeated updates to the same tag are allowed; the last one wins.
- Count:
  - `count` becomes `count` + push_accepted − pull_accepted.
  - A simultaneous accepted push and pull leaves `count` unchanged.
- Push and pull in the same cycle: both are evaluated on the pre-edge state. When full, the push is rejected even if a pull is accepted in the same cycle.
- Update collisions:
  - An update to the tag being pulled in the same cycle is discarded; the old value retires.
  - An update to the tag being pushed in the same cycle is ignored, because that slot is unallocated pre-edge; the push data is stored.
- Priority: `rst_i` > `flush_i` > push/pull/update.
- Reset/flush state:
  - all alloc and done = 0;
  - `head` = `tail` = 0, `count` = 0.
  - `data` is not cleared.
- Outputs after reset/flush: `valid_o` = 0, `value_o` = 0, `empty_o` = 1, `full_o` = 0, `count_o` = 0, `push_tag_o` = 0.
- A reset or flush asserted mid-operation discards all outstanding entries. It takes effect in the same edge as any concurrent push/pull/update, which are all lost.

## Timing
- All outputs are combinational from registered state only. There is no input-to-output combinational path.
- Push with `push_done_i` = 1 into an empty vector: `valid_o` = 1 and `value_o` = data on the cycle after the push edge.
- An update's effect on `valid_o`/`value_o` is visible 1 cycle after the update edge.
- Pull throughput: one entry per cycle when consecutive heads are done.
- `full_o`, `empty_o` and `count_o` reflect the post-edge count.
- `push_tag_o` advances by 1, mod `DEPTH`, per accepted push.

## Structure
- Shared package `status_vector_pkg`:
  - `clog2` function;
  - tag-width derivation.
  - Later status-vector variants reuse it.
- Sub-module `status_vector_slot`: one entry holding the alloc/done/data registers. Inputs are alloc/free/update strobes plus reset/flush. `DEPTH` instances are generated in the top.
- The top holds the pointers, the count, acceptance logic and the head read mux.

## Test plan
- Reset and basic push: `DEPTH`=4, `WIDTH`=8, reset, then push 0x11 with done=1. Expect tag 0, then `valid_o`=1, `value_o`=0x11, `count_o`=1.
- Out-of-order completion: push 0xA0, 0xA1, 0xA2 with done=0 (tags 0,1,2), then update tag 2=0x22 and tag 1=0x21. Expect `valid_o`=0. Update tag 0=0x20, then pull ×3. Expect `value_o` 0x20, 0x21, 0x22 in order, then `empty_o`=1.
- Full and wrap-around:
  - Fill 4 entries; expect `full_o`=1. Push 0x55 while full; expect it dropped and `count_o`=4.
  - Do push+pull in the same cycle while full; expect only the pull accepted, `count_o`=3.
  - Keep pushing; expect `push_tag_o` to wrap 3→0.
- Collisions:
  - Update the head tag in the same cycle as its pull; expect the old value retired.
  - Update an unallocated tag 3; expect no effect and a later push to tag 3 with done=0 not to show `valid_o`.
- Flush/reset mid-operation: with 3 entries outstanding, assert `flush_i` together with push/update. Expect `count_o`=0, `empty_o`=1, `push_tag_o`=0 next cycle, and a subsequent push to get tag 0.
- Pull on an undone head: head done=0 with `pull_i`=1 held 5 cycles. Expect no retire. Update the head; expect the pull accepted on the next edge.
